// File: rtl/sdram_init_pkg.sv
// rtl/sdram_init_pkg.sv - shared types and constants for the SDRAM power-up sequencer
// Contents: sequencer state enum, 4-bit {cs_n,ras_n,cas_n,we_n} command codes,
// and the CAS-latency field codes accepted in the mode register.
package sdram_init_pkg;

    typedef enum logic [3:0] {
        ST_RST,
        ST_WAIT_INIT,
        ST_PRE,
        ST_WAIT_RP,
        ST_AREF,
        ST_WAIT_RFC,
        ST_LMR,
        ST_WAIT_MRD,
        ST_DONE
    } state_t;

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    localparam logic [2:0] CL2 = 3'b010;
    localparam logic [2:0] CL3 = 3'b011;

endpackage

// File: rtl/init_timer.sv
// rtl/init_timer.sv - loadable down-counter with zero flag
// Ports: clk, rst_n (sync, active-low), load + load_val (reload), zero (count is 0).
// The count decrements every cycle until it reaches zero, then holds.
module init_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up sequencer with controller pass-through
// Ports: clk, rst_n (sync, active-low), init_req (re-run pulse, honoured in DONE),
// mode_reg (LMR value), ctl_* (controller command/address), sdr_* (SDRAM pins),
// init_done (pass-through active), cfg_err (sticky: bad CAS latency corrected).
module sdram_init_seq
    import sdram_init_pkg::*;
#(
    parameter int T_INIT = 10000,
    parameter int T_RP   = 3,
    parameter int T_RFC  = 7,
    parameter int N_REF  = 8,
    parameter int T_MRD  = 2,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    input  logic [ADDR_W-1:0] mode_reg,
    input  logic              ctl_cs_n,
    input  logic              ctl_ras_n,
    input  logic              ctl_cas_n,
    input  logic              ctl_we_n,
    input  logic [ADDR_W-1:0] ctl_addr,
    input  logic [1:0]        ctl_ba,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [1:0]        sdr_ba,
    output logic              init_done,
    output logic              cfg_err
);

    localparam int T_MAX_A = (T_INIT > T_RFC) ? T_INIT : T_RFC;
    localparam int T_MAX_B = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        ref_q, ref_d;
    logic              pend_q, pend_d;
    logic              cfg_err_q, cfg_err_d;
    logic              init_done_q, init_done_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              rfc_end;
    logic              cl_bad;
    logic [ADDR_W-1:0] mode_fix;

    init_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        cl_bad   = (mode_reg[6:4] != CL2) && (mode_reg[6:4] != CL3);
        mode_fix = mode_reg;
        if (cl_bad) begin
            mode_fix[6:4] = CL3;
        end
    end

    // Wait states are loaded with (T-2): the command cycle itself plus the
    // wait state's cycles through count zero add up to T cycles.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        pend_d    = pend_q;
        cfg_err_d = cfg_err_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        rfc_end   = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d  = ST_WAIT_INIT;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(T_INIT - 1);
            end
            ST_WAIT_INIT: begin
                if (tmr_zero) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (T_RP > 1) begin
                    state_d  = ST_WAIT_RP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_RP - 2);
                end else begin
                    state_d = ST_AREF;
                    ref_d   = 4'(N_REF - 1);
                end
            end
            ST_WAIT_RP: begin
                if (tmr_zero) begin
                    state_d = ST_AREF;
                    ref_d   = 4'(N_REF - 1);
                end
            end
            ST_AREF: begin
                if (T_RFC > 1) begin
                    state_d  = ST_WAIT_RFC;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_RFC - 2);
                end else begin
                    rfc_end = 1'b1;
                end
            end
            ST_WAIT_RFC: begin
                if (tmr_zero) rfc_end = 1'b1;
            end
            ST_LMR: begin
                // Flag is raised the cycle after LMR goes out.
                cfg_err_d = cfg_err_q | pend_q;
                if (T_MRD > 1) begin
                    state_d  = ST_WAIT_MRD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_MRD - 2);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_MRD: begin
                if (tmr_zero) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (init_req) begin
                    state_d  = ST_WAIT_INIT;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_INIT - 1);
                end
            end
            default: state_d = ST_RST;
        endcase

        // ref_q counts refreshes still to issue after the current one.
        if (rfc_end) begin
            if (ref_q != 4'd0) begin
                state_d = ST_AREF;
                ref_d   = ref_q - 4'd1;
            end else begin
                state_d = ST_LMR;
                pend_d  = cl_bad;
            end
        end

        // Outputs are decoded from the next state so they change with the state.
        cmd_d  = CMD_NOP;
        addr_d = '0;
        case (state_d)
            ST_PRE: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
            end
            ST_AREF: cmd_d = CMD_AREF;
            ST_LMR: begin
                cmd_d  = CMD_LMR;
                addr_d = mode_fix;
            end
            default: cmd_d = CMD_NOP;
        endcase
        init_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            cmd_q       <= CMD_DESEL;
            addr_q      <= '0;
            ref_q       <= 4'd0;
            pend_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ref_q       <= ref_d;
            pend_q      <= pend_d;
            cfg_err_q   <= cfg_err_d;
            init_done_q <= init_done_d;
        end
    end

    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = init_done_q ?
        {ctl_cs_n, ctl_ras_n, ctl_cas_n, ctl_we_n} : cmd_q;
    assign sdr_addr  = init_done_q ? ctl_addr : addr_q;
    assign sdr_ba    = init_done_q ? ctl_ba : 2'b00;
    assign init_done = init_done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - self-checking bench for sdram_init_seq
module tb_sdram_init_seq;

    localparam int T_INIT = 10;
    localparam int T_RP   = 3;
    localparam int T_RFC  = 7;
    localparam int N_REF  = 2;
    localparam int T_MRD  = 2;
    localparam int ADDR_W = 13;
    localparam int PRE_C  = T_INIT + 1;
    localparam int LMR_C  = PRE_C + T_RP + N_REF * T_RFC;
    localparam int DONE_C = LMR_C + T_MRD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_req = 1'b0;
    logic [ADDR_W-1:0] mode_reg = '0;
    logic              ctl_cs_n = 1'b1, ctl_ras_n = 1'b1, ctl_cas_n = 1'b1, ctl_we_n = 1'b1;
    logic [ADDR_W-1:0] ctl_addr = '0;
    logic [1:0]        ctl_ba = '0;
    logic              sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [ADDR_W-1:0] sdr_addr;
    logic [1:0]        sdr_ba;
    logic              init_done, cfg_err;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit exp_cfg  = 1'b0;

    sdram_init_seq #(
        .T_INIT(T_INIT), .T_RP(T_RP), .T_RFC(T_RFC),
        .N_REF(N_REF), .T_MRD(T_MRD), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .mode_reg(mode_reg),
        .ctl_cs_n(ctl_cs_n), .ctl_ras_n(ctl_ras_n), .ctl_cas_n(ctl_cas_n),
        .ctl_we_n(ctl_we_n), .ctl_addr(ctl_addr), .ctl_ba(ctl_ba),
        .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n),
        .sdr_we_n(sdr_we_n), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba),
        .init_done(init_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Address expected on the LMR cycle: illegal CAS latency replaced by CL3.
    function automatic logic [ADDR_W-1:0] lmr_addr(input logic [ADDR_W-1:0] m);
        logic [2:0] cl;
        cl = m[6:4];
        if (cl == 3'd2 || cl == 3'd3) return m;
        return (m & ~13'h0070) | 13'h0030;
    endfunction

    // Command the sequencer should drive on cycle k of a run (k >= 1, before DONE).
    function automatic logic [3:0] exp_sched(input int k);
        if (k <= T_INIT) return 4'b0111;
        if (k == PRE_C) return 4'b0010;
        for (int i = 0; i < N_REF; i++)
            if (k == PRE_C + T_RP + i * T_RFC) return 4'b0001;
        if (k == LMR_C) return 4'b0000;
        return 4'b0111;
    endfunction

    task automatic randomize_ctl();
        {ctl_cs_n, ctl_ras_n, ctl_cas_n, ctl_we_n} = 4'($urandom);
        ctl_addr = 13'($urandom);
        ctl_ba   = 2'($urandom);
    endtask

    // Runs cycles 1..ncyc of a sequence, checking every cycle against the schedule.
    task automatic run_seq(input int ncyc, input int req_cyc, input int rst_cyc);
        logic [3:0]        ecmd;
        logic [ADDR_W-1:0] eaddr;
        logic [1:0]        eba;
        logic              edone;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            init_req = 1'b0;
            randomize_ctl();
            #1;
            if (k >= DONE_C) begin
                ecmd  = {ctl_cs_n, ctl_ras_n, ctl_cas_n, ctl_we_n};
                eaddr = ctl_addr;
                eba   = ctl_ba;
            end else begin
                ecmd  = exp_sched(k);
                eaddr = (k == PRE_C) ? 13'h0400 : (k == LMR_C) ? lmr_addr(mode_reg) : 13'h0;
                eba   = 2'b00;
            end
            edone = (k >= DONE_C);
            if (k == LMR_C + 1 && lmr_addr(mode_reg) != mode_reg) exp_cfg = 1'b1;
            tot_cnt++;
            if ({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba} !== {ecmd, eaddr, eba}) begin
                $display("FAIL seq_pins cycle %0d: got cmd=%b addr=%h ba=%h, want cmd=%b addr=%h ba=%h",
                         k, {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, sdr_addr, sdr_ba, ecmd, eaddr, eba);
            end else pass_cnt++;
            tot_cnt++;
            if ({init_done, cfg_err} !== {edone, exp_cfg}) begin
                $display("FAIL seq_flags cycle %0d: got done=%b cfg_err=%b, want done=%b cfg_err=%b",
                         k, init_done, cfg_err, edone, exp_cfg);
            end else pass_cnt++;
            // Requests before DONE must be ignored.
            if (k < DONE_C && $urandom_range(0, 5) == 0) init_req = 1'b1;
            if (k == req_cyc) init_req = 1'b1;
            if (k == rst_cyc) rst_n = 1'b0;
        end
    endtask

    task automatic test_reset(input int hold);
        rst_n    = 1'b0;
        init_req = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            randomize_ctl();
            #1;
            tot_cnt++;
            if ({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba, init_done, cfg_err}
                !== {4'b1111, 13'h0, 2'b00, 1'b0, 1'b0}) begin
                $display("FAIL reset_hold cycle %0d: got cmd=%b addr=%h ba=%h done=%b cfg_err=%b, want 1111/0000/0/0/0",
                         i, {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, sdr_addr, sdr_ba, init_done, cfg_err);
            end else pass_cnt++;
        end
        init_req = 1'b0;
        rst_n    = 1'b1;
        exp_cfg  = 1'b0;
    endtask

    task automatic test_nominal();
        mode_reg = 13'h0032;
        test_reset(5);
        run_seq(DONE_C + 3, 0, 0);
    endtask

    task automatic test_passthrough();
        @(posedge clk);
        #1;
        {ctl_cs_n, ctl_ras_n, ctl_cas_n, ctl_we_n} = 4'b0101;
        ctl_addr = 13'h0123;
        ctl_ba   = 2'b10;
        #1;
        tot_cnt++;
        if ({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba} !== {4'b0101, 13'h0123, 2'b10}) begin
            $display("FAIL passthru_fixed: got cmd=%b addr=%h ba=%h, want 0101/0123/2",
                     {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, sdr_addr, sdr_ba);
        end else pass_cnt++;
        #2;
        ctl_addr = 13'h1ABC;
        ctl_we_n = 1'b0;
        #1;
        tot_cnt++;
        if ({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr} !== {4'b0100, 13'h1ABC}) begin
            $display("FAIL passthru_midcycle: got cmd=%b addr=%h, want 0100/1abc",
                     {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, sdr_addr);
        end else pass_cnt++;
    endtask

    task automatic test_init_req_done();
        @(posedge clk);
        #2;
        init_req = 1'b1;
        run_seq(DONE_C + 2, 0, 0);
    endtask

    task automatic test_reset_mid();
        mode_reg = 13'($urandom);
        test_reset(3);
        run_seq(18, 0, 18);
        @(posedge clk);
        #2;
        tot_cnt++;
        if ({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, init_done, cfg_err}
            !== {4'b1111, 13'h0, 1'b0, 1'b0}) begin
            $display("FAIL reset_mid: got cmd=%b addr=%h done=%b cfg_err=%b, want 1111/0000/0/0",
                     {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, sdr_addr, init_done, cfg_err);
        end else pass_cnt++;
        test_reset(2);
        run_seq(DONE_C + 1, 0, 0);
    endtask

    task automatic test_cas_error();
        mode_reg = 13'h0047;
        test_reset(4);
        run_seq(DONE_C + 1, 12, 0);
        // Rerun from DONE: the flag stays set.
        @(posedge clk);
        #2;
        init_req = 1'b1;
        run_seq(DONE_C + 1, 0, 0);
    endtask

    task automatic test_random_modes();
        for (int n = 0; n < 4; n++) begin
            mode_reg = 13'($urandom);
            test_reset($urandom_range(2, 6));
            run_seq(DONE_C + 2, $urandom_range(1, DONE_C - 1), 0);
        end
    endtask

    initial begin
        test_nominal();
        test_passthrough();
        test_init_req_done();
        test_reset_mid();
        test_cas_error();
        test_random_modes();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
